// File: rtl/riscv_pkg.sv
// Shared types for the register file and its write-back queue.
// Optional feature macro used by riscv_regfile_wb: REGFILE_RESET_CLEAR_EN.
package riscv_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    regaddr_t rd;
    xlen_t    data;
  } wb_entry_t;

  localparam regaddr_t REG_ZERO = 5'd0;
  localparam int       NUM_REGS = 32;

  function automatic logic entry_hits(input wb_entry_t e, input regaddr_t addr);
    return (e.rd == addr);
  endfunction

endpackage

// File: rtl/riscv_regfile_wb_fifo.sv
// Circular write-back queue of wb_entry_t. All slots, the occupancy mask and the
// read pointer are exported so the register file can search pending writes by age.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output wb_entry_t [DEPTH-1:0]  entries_o,
  output logic      [DEPTH-1:0]  valid_o,
  output logic      [PTR_W-1:0]  rd_ptr_o,
  output logic      [CNT_W-1:0]  count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] age_off;

  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_entry_i;

    wr_ptr_d = wr_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Count, not pointer equality, separates full from empty.
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    age_off = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_off    = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = (CNT_W'(age_off) < count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/riscv_regfile_wb.sv
// x0..x31 register file fed by a queued write-back port with read forwarding.
// Macro REGFILE_RESET_CLEAR_EN: when defined, reset also zeroes the array.
module riscv_regfile_wb
  import riscv_pkg::*;
#(
  parameter  int WB_DEPTH = 4,
  parameter  int XLEN     = 32,
  localparam int PTR_W    = $clog2(WB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  output logic [XLEN-1:0]          rv1,
  output logic [XLEN-1:0]          rv2,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     port_busy,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                     wb_empty
);

  // Write-back handshake: a transfer happens on a rising edge where wb_valid and
  // wb_ready are both high; wb_ready depends only on occupancy, never on wb_valid
  // or on a drain in the same cycle. Transfers to x0 complete but are discarded.

  wb_entry_t                push_entry;
  wb_entry_t                head;
  wb_entry_t [WB_DEPTH-1:0] entries;
  logic      [WB_DEPTH-1:0] valid_mask;
  logic      [PTR_W-1:0]    rd_ptr;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     accept, push, pop;

  logic                     arr_we;
  regaddr_t                 arr_waddr;
  xlen_t                    arr_wdata;
  xlen_t                    regs_q [NUM_REGS];
  xlen_t                    rv1_v, rv2_v;
  logic      [PTR_W-1:0]    idx;

  always_comb begin
    wb_ready        = !fifo_full;
    accept          = wb_valid && wb_ready;
    push            = accept && (wb_rd != REG_ZERO);
    pop             = !fifo_empty && !port_busy;
    push_entry.rd   = wb_rd;
    push_entry.data = xlen_t'(wb_data);
  end

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid_mask),
    .rd_ptr_o     (rd_ptr),
    .count_o      (wb_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign wb_empty = fifo_empty;

  // A drain coinciding with reset is suppressed so dropped entries never land.
  always_comb begin
    arr_we    = pop && rst_n;
    arr_waddr = head.rd;
    arr_wdata = head.data;
  end

`ifdef REGFILE_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (arr_we) begin
      regs_q[arr_waddr] <= arr_wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (arr_we) regs_q[arr_waddr] <= arr_wdata;
  end
`endif

  // Walk pending entries oldest to youngest so the youngest match wins.
  always_comb begin
    rv1_v = regs_q[rs1_addr];
    rv2_v = regs_q[rs2_addr];
    idx   = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_mask[idx] && entry_hits(entries[idx], rs1_addr)) rv1_v = entries[idx].data;
      if (valid_mask[idx] && entry_hits(entries[idx], rs2_addr)) rv2_v = entries[idx].data;
    end
    if (rs1_addr == REG_ZERO) rv1_v = '0;
    if (rs2_addr == REG_ZERO) rv2_v = '0;
  end

  assign rv1 = XLEN'(rv1_v);
  assign rv2 = XLEN'(rv2_v);

endmodule

// File: tb/tb_riscv_regfile_wb.sv
// Directed bench for riscv_regfile_wb with hand-computed expectations.
module tb_riscv_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rv1, rv2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        port_busy;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int checks = 0;
  int passed = 0;

  riscv_regfile_wb #(.WB_DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rv1       (rv1),
    .rv2       (rv2),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .port_busy (port_busy),
    .wb_count  (wb_count),
    .wb_empty  (wb_empty)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; port_busy = 1'b0; drive_wb(1'b0, 5'd0, 32'h0);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (wb_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", wb_count); else passed++;
    checks++; if (wb_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", wb_empty); else passed++;
    checks++; if (wb_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wb_ready); else passed++;
    drive_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    checks++; if (wb_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", wb_ready); else passed++;
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (wb_count !== 3'd0) $display("FAIL x0_count: got %0d want 0", wb_count); else passed++;
    checks++; if (wb_empty !== 1'b1) $display("FAIL x0_empty: got %b want 1", wb_empty); else passed++;
    checks++; if (rv1 !== 32'h0) $display("FAIL x0_read: got %h want 0", rv1); else passed++;
  endtask

  task automatic test_forwarding();
    port_busy = 1'b1;
    drive_wb(1'b1, 5'd5, 32'h0000_0011);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    rs1_addr = 5'd5;
    #1;
    checks++; if (rv1 !== 32'h11) $display("FAIL fwd_value: got %h want 00000011", rv1); else passed++;
    checks++; if (wb_count !== 3'd1) $display("FAIL fwd_count: got %0d want 1", wb_count); else passed++;
    port_busy = 1'b0;
    tick();
    checks++; if (rv1 !== 32'h11) $display("FAIL fwd_after_drain: got %h want 00000011", rv1); else passed++;
    checks++; if (wb_empty !== 1'b1) $display("FAIL fwd_empty: got %b want 1", wb_empty); else passed++;
    // A write in its accept cycle must not be visible yet.
    port_busy = 1'b1;
    drive_wb(1'b1, 5'd5, 32'h0000_0022);
    #1;
    checks++; if (rv1 !== 32'h11) $display("FAIL fwd_not_same_cycle: got %h want 00000011", rv1); else passed++;
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (rv1 !== 32'h22) $display("FAIL fwd_next_cycle: got %h want 00000022", rv1); else passed++;
    // Entry being drained this cycle is still forwarded over the stale array value.
    port_busy = 1'b0;
    #1;
    checks++; if (rv1 !== 32'h22) $display("FAIL fwd_draining: got %h want 00000022", rv1); else passed++;
    tick();
    checks++; if (rv1 !== 32'h22) $display("FAIL fwd_array: got %h want 00000022", rv1); else passed++;
  endtask

  task automatic test_youngest();
    port_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_wb(1'b1, 5'd7, 32'(i));
      tick();
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    rs2_addr = 5'd7;
    #1;
    checks++; if (rv2 !== 32'd3) $display("FAIL young_fwd: got %h want 3", rv2); else passed++;
    checks++; if (wb_count !== 3'd3) $display("FAIL young_count: got %0d want 3", wb_count); else passed++;
    port_busy = 1'b0;
    tick();
    checks++; if (rv2 !== 32'd3) $display("FAIL young_mid_drain: got %h want 3", rv2); else passed++;
    tick();
    tick();
    checks++; if (wb_empty !== 1'b1) $display("FAIL young_empty: got %b want 1", wb_empty); else passed++;
    checks++; if (rv2 !== 32'd3) $display("FAIL young_array: got %h want 3", rv2); else passed++;
  endtask

  task automatic test_full();
    port_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_wb(1'b1, 5'(10 + i), 32'h0000_00A0 + 32'(i));
      tick();
    end
    drive_wb(1'b1, 5'd14, 32'h0000_00EE);
    #1;
    checks++; if (wb_count !== 3'd4) $display("FAIL full_count: got %0d want 4", wb_count); else passed++;
    checks++; if (wb_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wb_ready); else passed++;
    tick();
    checks++; if (wb_count !== 3'd4) $display("FAIL full_hold: got %0d want 4", wb_count); else passed++;
    // Drain while full: ready stays low, so the held fifth request is still refused.
    port_busy = 1'b0;
    #1;
    checks++; if (wb_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", wb_ready); else passed++;
    tick();
    port_busy = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (wb_count !== 3'd3) $display("FAIL full_after_pop: got %0d want 3", wb_count); else passed++;
    checks++; if (wb_ready !== 1'b1) $display("FAIL full_ready_back: got %b want 1", wb_ready); else passed++;
    port_busy = 1'b0;
    tick(); tick(); tick();
    checks++; if (wb_empty !== 1'b1) $display("FAIL full_drained: got %b want 1", wb_empty); else passed++;
    for (int i = 0; i < 4; i++) begin
      rs1_addr = 5'(10 + i);
      #1;
      checks++;
      if (rv1 !== 32'h0000_00A0 + 32'(i)) $display("FAIL full_x%0d: got %h want %h", 10 + i, rv1, 32'h0000_00A0 + 32'(i));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    port_busy = 1'b1;
    drive_wb(1'b1, 5'd20, 32'h0000_0200); tick();
    drive_wb(1'b1, 5'd21, 32'h0000_0201); tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (wb_count !== 3'd2) $display("FAIL b2b_start: got %0d want 2", wb_count); else passed++;
    port_busy = 1'b0;
    rs1_addr = 5'd9;
    for (int i = 0; i < 10; i++) begin
      exp_d = 32'h0000_A5A5 + 32'(i);
      drive_wb(1'b1, 5'd9, exp_d);
      tick();
      checks++; if (wb_count !== 3'd2) $display("FAIL b2b_count_%0d: got %0d want 2", i, wb_count); else passed++;
      checks++; if (rv1 !== exp_d) $display("FAIL b2b_fwd_%0d: got %h want %h", i, rv1, exp_d); else passed++;
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (wb_count !== 3'd1) $display("FAIL b2b_tail1: got %0d want 1", wb_count); else passed++;
    tick();
    checks++; if (wb_empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", wb_empty); else passed++;
    checks++; if (rv1 !== 32'h0000_A5AE) $display("FAIL b2b_x9: got %h want 0000a5ae", rv1); else passed++;
    rs1_addr = 5'd20; rs2_addr = 5'd21;
    #1;
    checks++; if (rv1 !== 32'h0000_0200) $display("FAIL b2b_x20: got %h want 00000200", rv1); else passed++;
    checks++; if (rv2 !== 32'h0000_0201) $display("FAIL b2b_x21: got %h want 00000201", rv2); else passed++;
  endtask

  task automatic test_reset_midflight();
    port_busy = 1'b1;
    drive_wb(1'b1, 5'd10, 32'h1111_0000); tick();
    drive_wb(1'b1, 5'd11, 32'h2222_0000); tick();
    drive_wb(1'b1, 5'd12, 32'h3333_0000); tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (wb_count !== 3'd3) $display("FAIL mid_pending: got %0d want 3", wb_count); else passed++;
    // Port freed during reset: the dropped head must still not be written.
    rst_n = 1'b0;
    port_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (wb_count !== 3'd0) $display("FAIL mid_count: got %0d want 0", wb_count); else passed++;
    checks++; if (wb_empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", wb_empty); else passed++;
    checks++; if (wb_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", wb_ready); else passed++;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      rs1_addr = 5'(10 + i);
      #1;
`ifdef REGFILE_RESET_CLEAR_EN
      checks++; if (rv1 !== 32'h0) $display("FAIL mid_x%0d: got %h want 0", 10 + i, rv1); else passed++;
`else
      checks++;
      if (rv1 !== 32'h0000_00A0 + 32'(i)) $display("FAIL mid_x%0d: got %h want %h", 10 + i, rv1, 32'h0000_00A0 + 32'(i));
      else passed++;
`endif
    end
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
`ifdef REGFILE_RESET_CLEAR_EN
    checks++; if (rv1 !== 32'h0) $display("FAIL mid_x5: got %h want 0", rv1); else passed++;
    checks++; if (rv2 !== 32'h0) $display("FAIL mid_x7: got %h want 0", rv2); else passed++;
`else
    checks++; if (rv1 !== 32'h22) $display("FAIL mid_x5: got %h want 00000022", rv1); else passed++;
    checks++; if (rv2 !== 32'h3) $display("FAIL mid_x7: got %h want 3", rv2); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_youngest();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_wb.md
Name: riscv_regfile_wb

Overview:
- Architectural register file, x0..x31, for the single-cycle RISC-V core.
- Supplies the rv1/rv2 operand values consumed by the R-type ALU.
- Accepts ALU results (regdata) through a valid/ready write-back port into a small FIFO.
- The FIFO drains into the array one entry per cycle whenever the shared write port is free.
- Reads forward the youngest pending write, so operands are always architecturally current.

Parameters:
- WB_DEPTH, 4: write-back FIFO entries (power of 2, ≥2).
- XLEN, 32: register width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rs1_addr  in  5  source register 1 index (idata[19:15]).
- rs2_addr  in  5  source register 2 index (idata[24:20]).
- rv1  out  XLEN  operand 1, combinational.
- rv2  out  XLEN  operand 2, combinational.
- wb_valid  in  1  write-back request.
- wb_ready  out  1  FIFO can accept.
- wb_rd  in  5  destination index.
- wb_data  in  XLEN  result (regdata_R).
- port_busy  in  1  array write port taken by another writer; blocks drain.
- wb_count  out  $clog2(WB_DEPTH)+1  FIFO occupancy.
- wb_empty  out  1  no pending writes.

Behaviour:
- Reset (rst_n=0 at posedge): FIFO rd/wr pointers and count cleared.
  - wb_count=0, wb_empty=1, wb_ready=1.
  - Array contents per optional feature.
- Accept: a handshake occurs when wb_valid && wb_ready at posedge.
  - An entry with wb_rd=0 completes the handshake but is discarded (count unchanged).
- wb_ready = (count < WB_DEPTH). It is purely count-based; there is no same-cycle full bypass.
  - Full with a drain in the same cycle still gives ready=0.
- Drain: if !wb_empty && !port_busy at posedge, the head entry is written to the array and popped.
  - Latency from accept to array write is ≥1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo WB_DEPTH.
  - Count distinguishes full from empty (WB_DEPTH states plus 0).
- Read path, per port:
  - Address 0 returns 0.
  - Otherwise return the youngest valid FIFO entry with matching rd.
  - Otherwise return the array value.
  - A write being accepted in the current cycle is NOT forwarded; it is visible from the next cycle.
  - An entry being drained this cycle is still forwarded this cycle.
- Multiple pending entries to the same rd drain in order; the array ends with the youngest value.
- port_busy held high indefinitely: FIFO fills, ready drops, no data lost.
- Reset mid-operation: pending FIFO entries are dropped (not written).

Optional Feature:
- REGFILE_RESET_CLEAR_EN
  - Defined: reset also clears x1..x31 to 0.
  - Undefined: array has no reset; contents hold across reset and are X from power-up. Only FIFO state resets.
- x0 reads 0 in both cases.

Decomposition:
- riscv_pkg additions:
  - regaddr_t (logic [4:0]).
  - xlen_t (logic [31:0]).
  - wb_entry_t struct {regaddr_t rd; xlen_t data;}.
  - Constant REG_ZERO = 5'd0.
- One sub-module: wb_fifo.
  - Parameterised FIFO of wb_entry_t.
  - Exposes all entries plus valid mask for the forwarding search.
  - Top module holds the array and read muxes.

Test Plan:
- Reset and x0: rst_n=0 one cycle, then write rd=0 data=32'hDEAD_BEEF.
  - wb_ready=1, handshake accepted, wb_count stays 0, rs1=0 reads 0.
- Forwarding: port_busy=1, write x5=32'h0000_0011, next cycle rs1=5 → rv1=32'h11 while wb_count=1.
  - Release port_busy; after drain rv1 is still 32'h11, wb_empty=1.
- Youngest wins: port_busy=1, write x7=1, x7=2, x7=3.
  - rv2 (rs2=7)=3.
  - Release; after 3 drains rv2=3, array x7=3.
- Full: port_busy=1, WB_DEPTH=4, push 4 entries.
  - wb_ready=0, wb_count=4.
  - Fifth wb_valid held is not accepted.
  - Release one cycle: count=3, ready=1.
- Simultaneous push/pop at count=2: write x9=32'hA5A5 with port_busy=0.
  - Count stays 2, pointers wrap correctly across 8+ iterations.
  - Values read back match a reference model.
- Reset mid-flight: 3 pending with port_busy=1, assert rst_n=0.
  - Count=0, pending regs not updated.
  - With REGFILE_RESET_CLEAR_EN all x1..x31 read 0.
  - Without it, prior values remain.
